rtc_timekeeper: RTL and testbench

- Parametrised real-time clock core for the user project area. Clocked from the Caravel core clock.
- Divides the clock down to a 1 Hz tick and keeps seconds/minutes/hours/day counters.
- Accepts validated time loads through a valid/ready handshake.
- Provides NUM_ALARMS programmable alarm channels with sticky, clearable flags routed to mprj_io/IRQ.
- Successor to the fixed single-counter RTC demo: adds prescaler width generality, loadable time, range checking and multi-channel alarms.

---
 rtl/rtc_pkg.sv | 30 +++
 rtl/rtc_alarm_cmp.sv | 37 +++
 rtl/rtc_timekeeper.sv | 132 +++++++++++++
 tb/tb_rtc_timekeeper.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and limits for the RTC timekeeper.
// Time-of-day field widths, bounds and the load range check.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  typedef enum logic {
    LD_IDLE,
    LD_COMMIT
  } ld_state_t;

  function automatic logic time_ok(time_t t);
    return (t.sec <= SEC_MAX) &&
           (t.min <= MIN_MAX) &&
           (t.hour <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/rtc_alarm_cmp.sv
// One alarm channel: enable, compare time and sticky flag.
// The flag is only set on a time-change strobe; set beats clear.
module rtc_alarm_cmp
  import rtc_pkg::*;
(
  input  logic  clock,
  input  logic  resetb,
  input  logic  wr,
  input  logic  en_in,
  input  time_t wr_time,
  input  logic  chg,
  input  time_t now,
  input  logic  clr,
  output logic  flag
);

  logic  en_q;
  time_t alm;
  logic  hit;

  assign hit = chg && en_q && (now == alm);

  always_ff @(posedge clock) begin
    if (!resetb) begin
      en_q <= 1'b0;
      alm  <= '0;
      flag <= 1'b0;
    end else begin
      if (wr) begin
        en_q <= en_in;
        alm  <= wr_time;
      end
      flag <= hit | (flag & ~clr);
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// RTC core: prescaler, sec/min/hour/day carry chain,
// validated time load handshake and alarm channels.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 40000000,
  parameter int NUM_ALARMS  = 2,
  parameter int DAY_W       = 16,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int PW    = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [SEC_W-1:0]      load_sec,
  input  logic [MIN_W-1:0]      load_min,
  input  logic [HOUR_W-1:0]     load_hour,
  input  logic [DAY_W-1:0]      load_day,
  output logic                  load_err,
  input  logic                  alarm_wr,
  input  logic [IDX_W-1:0]      alarm_idx,
  input  logic                  alarm_en_in,
  input  logic [SEC_W-1:0]      alarm_sec,
  input  logic [MIN_W-1:0]      alarm_min,
  input  logic [HOUR_W-1:0]     alarm_hour,
  input  logic [NUM_ALARMS-1:0] alarm_clr,
  output logic [SEC_W-1:0]      sec,
  output logic [MIN_W-1:0]      min,
  output logic [HOUR_W-1:0]     hour,
  output logic [DAY_W-1:0]      day,
  output logic                  tick_1hz,
  output logic [NUM_ALARMS-1:0] alarm_flag
);

  localparam logic [PW-1:0] TC = PW'(CLK_FREQ_HZ - 1);

  ld_state_t        state;
  logic [PW-1:0]    presc;
  time_t            now;
  logic [DAY_W-1:0] day_q;
  time_t            ld_t;
  time_t            alm_t;
  logic             accept;
  logic             ld_ok;
  logic             wrap;
  logic             chg;

  assign ld_t   = '{hour: load_hour, min: load_min, sec: load_sec};
  assign alm_t  = '{hour: alarm_hour, min: alarm_min, sec: alarm_sec};
  assign accept = load_valid & load_ready;
  assign ld_ok  = time_ok(ld_t);
  assign wrap   = en && (presc == TC);

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state      <= LD_IDLE;
      load_ready <= 1'b1;
      load_err   <= 1'b0;
      presc      <= '0;
      now        <= '0;
      day_q      <= '0;
      tick_1hz   <= 1'b0;
      chg        <= 1'b0;
    end else begin
      tick_1hz <= 1'b0;
      load_err <= 1'b0;
      chg      <= 1'b0;
      if (en) presc <= wrap ? '0 : presc + PW'(1);
      unique case (state)
        LD_IDLE: if (accept) begin
          state      <= LD_COMMIT;
          load_ready <= 1'b0;
        end
        LD_COMMIT: begin
          state      <= LD_IDLE;
          load_ready <= 1'b1;
        end
      endcase
      // A good load overrides a coincident wrap; a bad one is inert.
      if (accept && ld_ok) begin
        now   <= ld_t;
        day_q <= load_day;
        presc <= '0;
        chg   <= 1'b1;
      end else begin
        if (accept) load_err <= 1'b1;
        if (wrap) begin
          tick_1hz <= 1'b1;
          chg      <= 1'b1;
          if (now.sec == SEC_MAX) begin
            now.sec <= '0;
            if (now.min == MIN_MAX) begin
              now.min <= '0;
              if (now.hour == HOUR_MAX) begin
                now.hour <= '0;
                day_q    <= day_q + DAY_W'(1);
              end else begin
                now.hour <= now.hour + HOUR_W'(1);
              end
            end else begin
              now.min <= now.min + MIN_W'(1);
            end
          end else begin
            now.sec <= now.sec + SEC_W'(1);
          end
        end
      end
    end
  end

  assign sec  = now.sec;
  assign min  = now.min;
  assign hour = now.hour;
  assign day  = day_q;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alm
    rtc_alarm_cmp u_cmp (
      .clock   (clock),
      .resetb  (resetb),
      .wr      (alarm_wr && (alarm_idx == IDX_W'(i))),
      .en_in   (alarm_en_in),
      .wr_time (alm_t),
      .chg     (chg),
      .now     (now),
      .clr     (alarm_clr[i]),
      .flag    (alarm_flag[i])
    );
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper at CLK_FREQ_HZ=4.
// Stimulus queues expected events; a negedge monitor checks them.
module tb_rtc_timekeeper;

  localparam int NA = 2;
  localparam int DW = 16;

  localparam int S_TIME = 0;
  localparam int S_RDY  = 1;
  localparam int S_FLAG = 2;
  localparam int S_TICK = 3;
  localparam int S_ERR  = 4;

  logic          clock;
  logic          resetb;
  logic          en;
  logic          load_valid;
  logic          load_ready;
  logic [5:0]    load_sec;
  logic [5:0]    load_min;
  logic [4:0]    load_hour;
  logic [DW-1:0] load_day;
  logic          load_err;
  logic          alarm_wr;
  logic [0:0]    alarm_idx;
  logic          alarm_en_in;
  logic [5:0]    alarm_sec;
  logic [5:0]    alarm_min;
  logic [4:0]    alarm_hour;
  logic [NA-1:0] alarm_clr;
  logic [5:0]    sec;
  logic [5:0]    min;
  logic [4:0]    hour;
  logic [DW-1:0] day;
  logic          tick_1hz;
  logic [NA-1:0] alarm_flag;

  rtc_timekeeper #(
    .CLK_FREQ_HZ (4),
    .NUM_ALARMS  (NA),
    .DAY_W       (DW)
  ) dut (
    .clock       (clock),
    .resetb      (resetb),
    .en          (en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_sec    (load_sec),
    .load_min    (load_min),
    .load_hour   (load_hour),
    .load_day    (load_day),
    .load_err    (load_err),
    .alarm_wr    (alarm_wr),
    .alarm_idx   (alarm_idx),
    .alarm_en_in (alarm_en_in),
    .alarm_sec   (alarm_sec),
    .alarm_min   (alarm_min),
    .alarm_hour  (alarm_hour),
    .alarm_clr   (alarm_clr),
    .sec         (sec),
    .min         (min),
    .hour        (hour),
    .day         (day),
    .tick_1hz    (tick_1hz),
    .alarm_flag  (alarm_flag)
  );

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
  } snap_t;

  exp_t  tick_q[$];
  exp_t  err_q[$];
  exp_t  flag_q[$];
  snap_t snap_q[$];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            mon_on = 0;
  logic [NA-1:0] flag_prev = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] tv(int d, int h, int m, int s);
    return {31'b0, 16'(d), 5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] snap_val(int sel);
    case (sel)
      S_TIME:  return {31'b0, day, hour, min, sec};
      S_RDY:   return 64'(load_ready);
      S_FLAG:  return 64'(alarm_flag);
      S_TICK:  return 64'(tick_1hz);
      default: return 64'(load_err);
    endcase
  endfunction

  always @(negedge clock) begin
    exp_t  e;
    snap_t s;
    if (mon_on) begin
      if (tick_1hz === 1'b1) begin
        chk("tick_pending", 64'(tick_q.size() != 0), 64'd1);
        if (tick_q.size() != 0) begin
          e = tick_q.pop_front();
          chk("tick_cyc", 64'(cyc), 64'(e.cyc));
          chk("tick_time", {31'b0, day, hour, min, sec}, e.val);
        end
      end
      if (load_err === 1'b1) begin
        chk("err_pending", 64'(err_q.size() != 0), 64'd1);
        if (err_q.size() != 0) begin
          e = err_q.pop_front();
          chk("err_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
      if (alarm_flag !== flag_prev) begin
        chk("flag_pending", 64'(flag_q.size() != 0), 64'd1);
        if (flag_q.size() != 0) begin
          e = flag_q.pop_front();
          chk("flag_cyc", 64'(cyc), 64'(e.cyc));
          chk("flag_val", 64'(alarm_flag), e.val);
        end
      end
      while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
        s = snap_q.pop_front();
        chk("snap_due", 64'(cyc), 64'(s.cyc));
        chk($sformatf("snap_sel%0d", s.sel), snap_val(s.sel), s.val);
      end
    end
    flag_prev = alarm_flag;
  end

  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tk(int c, int d, int h, int m, int s);
    tick_q.push_back('{cyc: c, val: tv(d, h, m, s)});
  endtask

  task automatic sn(int c, int sel, logic [63:0] v);
    snap_q.push_back('{cyc: c, sel: sel, val: v});
  endtask

  task automatic ld(int h, int m, int s, int d);
    load_valid = 1'b1;
    load_hour  = 5'(h);
    load_min   = 6'(m);
    load_sec   = 6'(s);
    load_day   = 16'(d);
  endtask

  task automatic aw(int idx, int e, int h, int m, int s);
    alarm_wr    = 1'b1;
    alarm_idx   = 1'(idx);
    alarm_en_in = 1'(e);
    alarm_hour  = 5'(h);
    alarm_min   = 6'(m);
    alarm_sec   = 6'(s);
  endtask

  initial begin
    resetb = 1'b0;
    en = 1'b0;
    load_valid = 1'b0;
    load_sec = '0;
    load_min = '0;
    load_hour = '0;
    load_day = '0;
    alarm_wr = 1'b0;
    alarm_idx = '0;
    alarm_en_in = 1'b0;
    alarm_sec = '0;
    alarm_min = '0;
    alarm_hour = '0;
    alarm_clr = '0;

    // reset state and free-running seconds
    goto(3);
    resetb = 1'b1;
    en = 1'b1;
    mon_on = 1'b1;
    sn(3, S_TIME, tv(0, 0, 0, 0));
    sn(3, S_RDY, 64'd1);
    sn(3, S_FLAG, 64'd0);
    sn(3, S_TICK, 64'd0);
    sn(3, S_ERR, 64'd0);
    tk(7, 0, 0, 0, 1);
    tk(11, 0, 0, 0, 2);
    tk(15, 0, 0, 0, 3);
    goto(15);
    en = 1'b0;
    sn(16, S_TIME, tv(0, 0, 0, 3));
    sn(16, S_TICK, 64'd0);

    // carry chain and day wrap
    goto(16);
    ld(23, 59, 58, 5);
    sn(17, S_RDY, 64'd0);
    sn(17, S_TIME, tv(5, 23, 59, 58));
    sn(18, S_RDY, 64'd1);
    goto(17);
    load_valid = 1'b0;
    goto(18);
    en = 1'b1;
    tk(22, 5, 23, 59, 59);
    tk(26, 6, 0, 0, 0);
    goto(26);
    en = 1'b0;
    goto(27);
    ld(23, 59, 59, 65535);
    sn(28, S_TIME, tv(65535, 23, 59, 59));
    goto(28);
    load_valid = 1'b0;
    goto(29);
    en = 1'b1;
    tk(33, 0, 0, 0, 0);
    goto(33);
    en = 1'b0;

    // out-of-range loads
    goto(34);
    ld(0, 0, 60, 7);
    err_q.push_back('{cyc: 35, val: 64'd1});
    sn(35, S_RDY, 64'd0);
    sn(35, S_TIME, tv(0, 0, 0, 0));
    sn(36, S_RDY, 64'd1);
    sn(36, S_ERR, 64'd0);
    goto(35);
    load_valid = 1'b0;
    goto(36);
    ld(24, 0, 0, 7);
    err_q.push_back('{cyc: 37, val: 64'd1});
    sn(37, S_RDY, 64'd0);
    sn(37, S_TIME, tv(0, 0, 0, 0));
    sn(38, S_RDY, 64'd1);
    goto(37);
    load_valid = 1'b0;

    // alarms: enabled vs disabled channel, set beats clear
    goto(38);
    aw(0, 1, 0, 0, 2);
    goto(39);
    aw(1, 0, 0, 0, 2);
    goto(40);
    alarm_wr = 1'b0;
    en = 1'b1;
    tk(44, 0, 0, 0, 1);
    tk(48, 0, 0, 0, 2);
    flag_q.push_back('{cyc: 49, val: 64'd1});
    goto(48);
    en = 1'b0;
    goto(50);
    ld(0, 0, 2, 0);
    goto(51);
    load_valid = 1'b0;
    alarm_clr = 2'b01;
    sn(52, S_FLAG, 64'd1);
    goto(52);
    alarm_clr = 2'b00;
    goto(53);
    alarm_clr = 2'b01;
    flag_q.push_back('{cyc: 54, val: 64'd0});
    goto(54);
    alarm_clr = 2'b00;

    // load on the prescaler terminal cycle
    goto(55);
    en = 1'b1;
    goto(58);
    ld(10, 20, 30, 3);
    sn(59, S_TIME, tv(3, 10, 20, 30));
    sn(59, S_TICK, 64'd0);
    sn(59, S_RDY, 64'd0);
    tk(63, 3, 10, 20, 31);
    goto(59);
    load_valid = 1'b0;
    goto(63);
    en = 1'b0;

    // reset mid-count clears alarms and flags
    goto(64);
    aw(1, 1, 10, 20, 33);
    goto(65);
    alarm_wr = 1'b0;
    en = 1'b1;
    tk(69, 3, 10, 20, 32);
    tk(73, 3, 10, 20, 33);
    flag_q.push_back('{cyc: 74, val: 64'd2});
    goto(75);
    resetb = 1'b0;
    flag_q.push_back('{cyc: 76, val: 64'd0});
    sn(76, S_TIME, tv(0, 0, 0, 0));
    sn(76, S_RDY, 64'd1);
    sn(76, S_TICK, 64'd0);
    sn(76, S_ERR, 64'd0);
    goto(76);
    resetb = 1'b1;
    tk(80, 0, 0, 0, 1);
    tk(84, 0, 0, 0, 2);
    tk(88, 0, 0, 0, 3);
    goto(88);
    en = 1'b0;
    sn(90, S_FLAG, 64'd0);
    sn(90, S_TIME, tv(0, 0, 0, 3));

    goto(92);
    chk("tick_q_left", 64'(tick_q.size()), 64'd0);
    chk("err_q_left", 64'(err_q.size()), 64'd0);
    chk("flag_q_left", 64'(flag_q.size()), 64'd0);
    chk("snap_q_left", 64'(snap_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
